// File: rtl/palette_lut.sv
// Banked colour palette lookup with a two-stage read pipeline.
// Bank switches are deferred to frame boundaries.
module palette_lut #(
  parameter int IDX_W     = 8,
  parameter int CH_W      = 4,
  parameter int NBANK     = 2,
  parameter int TRANS_IDX = 0,
  parameter int BANK_W    = (NBANK > 2) ? $clog2(NBANK) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  index,
  input  logic              frame_start,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  input  logic              bank_req_we,
  input  logic [BANK_W-1:0] bank_req,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_valid,
  output logic              out_transp,
  output logic [BANK_W-1:0] active_bank,
  output logic              bank_pend
);

  localparam int DEPTH = 2**IDX_W;
  localparam int WORDS = NBANK * DEPTH;
  localparam int AW    = BANK_W + IDX_W;
  localparam int DW    = 3 * CH_W;

  localparam logic [BANK_W:0]  LP_NBANK = (BANK_W+1)'(NBANK);
  localparam logic [IDX_W-1:0] LP_TRANS = IDX_W'(TRANS_IDX);

  logic [DW-1:0]     r_mem [WORDS];
  logic [DW-1:0]     r_rd_data;
  logic              r_s1_valid;
  logic [IDX_W-1:0]  r_s1_idx;
  logic [DW-1:0]     r_rgb;
  logic              r_out_valid;
  logic              r_out_transp;
  logic [BANK_W-1:0] r_bank;
  logic [BANK_W-1:0] r_pend_bank;
  logic              r_pend;

  logic              w_wr_ok;
  logic              w_req_ok;
  logic              w_s1_transp;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;

  assign w_wr_ok     = wr_en && ({1'b0, wr_bank} < LP_NBANK);
  assign w_req_ok    = bank_req_we && ({1'b0, bank_req} < LP_NBANK);
  assign w_wr_addr   = {wr_bank, wr_addr};
  assign w_rd_addr   = {r_bank, index};
  assign w_s1_transp = (r_s1_idx == LP_TRANS);

  // Read and write on the same edge: the read sees the pre-write word.
  always_ff @(posedge Clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_idx     <= '0;
      r_out_valid  <= 1'b0;
      r_out_transp <= 1'b0;
      r_rgb        <= '0;
    end else begin
      r_s1_valid   <= pix_valid;
      r_s1_idx     <= index;
      r_out_valid  <= r_s1_valid;
      r_out_transp <= r_s1_valid && w_s1_transp;
      r_rgb        <= r_s1_valid ? r_rd_data : '0;
    end
  end

  // A request on the frame edge itself bypasses the pending slot.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_bank      <= '0;
      r_pend_bank <= '0;
      r_pend      <= 1'b0;
    end else if (frame_start && w_req_ok) begin
      r_bank      <= bank_req;
      r_pend      <= 1'b0;
    end else if (frame_start && r_pend) begin
      r_bank      <= r_pend_bank;
      r_pend      <= 1'b0;
    end else if (w_req_ok) begin
      r_pend_bank <= bank_req;
      r_pend      <= 1'b1;
    end
  end

  assign {red, green, blue} = r_rgb;
  assign out_valid          = r_out_valid;
  assign out_transp         = r_out_transp;
  assign active_bank        = r_bank;
  assign bank_pend          = r_pend;

endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: a shadow palette predicts
// every pixel, popped when its output cycle arrives.
module tb_palette_lut;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [7:0]  index = '0;
  logic        frame_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_bank = '0;
  logic [7:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        bank_req_we = 1'b0;
  logic [0:0]  bank_req = '0;
  logic [3:0]  red, green, blue;
  logic        out_valid, out_transp;
  logic [0:0]  active_bank;
  logic        bank_pend;

  palette_lut dut (
    .Clk(Clk), .Reset(Reset),
    .pix_valid(pix_valid), .index(index),
    .frame_start(frame_start),
    .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .bank_req_we(bank_req_we), .bank_req(bank_req),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .out_transp(out_transp),
    .active_bank(active_bank), .bank_pend(bank_pend)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    int unsigned e;
    logic [11:0] rgb;
    logic        tr;
  } exp_t;

  exp_t        q[$];
  logic [11:0] mem_m [2][256];
  logic [0:0]  m_bank = '0;
  logic [0:0]  m_pendv = '0;
  logic        m_pend = 1'b0;
  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] pat(input int b, input int i);
    if (b == 0 && i == 5)    return 12'h7A3;
    if (b == 0 && i == 'h10) return 12'h111;
    if (b == 1 && i == 5)    return 12'hBD8;
    if (b == 0)              return 12'(i * 37 + 11);
    return 12'(i * 91 + 'h5A5);
  endfunction

  task automatic cyc();
    exp_t x;
    if (pix_valid) begin
      x.e   = edge_cnt + 2;
      x.rgb = mem_m[m_bank][index];
      x.tr  = (index == 8'h00);
      q.push_back(x);
    end
    if (wr_en) mem_m[wr_bank][wr_addr] = wr_data;
    if (frame_start && bank_req_we) begin
      m_bank = bank_req;
      m_pend = 1'b0;
    end else if (frame_start && m_pend) begin
      m_bank = m_pendv;
      m_pend = 1'b0;
    end else if (bank_req_we) begin
      m_pendv = bank_req;
      m_pend  = 1'b1;
    end
    @(posedge Clk);
    edge_cnt++;
    #1;
    if (q.size() > 0 && q[0].e == edge_cnt) begin
      x = q.pop_front();
      chk("valid", 32'(out_valid), 32'd1);
      chk("rgb", 32'({red, green, blue}), 32'(x.rgb));
      chk("transp", 32'(out_transp), 32'(x.tr));
    end else begin
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_out", 32'({out_transp, red, green, blue}), 32'd0);
    end
    chk("bank", 32'(active_bank), 32'(m_bank));
    chk("pend", 32'(bank_pend), 32'(m_pend));
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    wr_en = 1'b0;
    bank_req_we = 1'b0;
    frame_start = 1'b0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic pix(input logic [7:0] i);
    pix_valid = 1'b1;
    index = i;
    cyc();
  endtask

  initial begin
    #1;
    chk("rst_out", 32'({out_valid, out_transp, red, green, blue}), 32'd0);
    chk("rst_bank", 32'({active_bank, bank_pend}), 32'd0);
    @(posedge Clk); edge_cnt++;
    @(posedge Clk); edge_cnt++;
    #2 Reset = 1'b0;

    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 256; i++) begin
        wr_en = 1'b1;
        wr_bank = 1'(b);
        wr_addr = 8'(i);
        wr_data = pat(b, i);
        cyc();
      end
    end
    wr_en = 1'b0;

    pix(8'h05);
    idle(3);

    for (int i = 0; i < 256; i++) pix(8'(i));
    idle(3);

    wr_en = 1'b1;
    wr_bank = 1'b0;
    wr_addr = 8'h10;
    wr_data = 12'h222;
    pix(8'h10);
    wr_en = 1'b0;
    pix(8'h10);
    idle(3);

    bank_req_we = 1'b1;
    bank_req = 1'b1;
    pix(8'h05);
    bank_req_we = 1'b0;
    chk("pend_set", 32'(bank_pend), 32'd1);
    pix(8'h05);
    pix(8'h05);
    frame_start = 1'b1;
    pix(8'h05);
    frame_start = 1'b0;
    chk("pend_clr", 32'(bank_pend), 32'd0);
    chk("bank_sw", 32'(active_bank), 32'd1);
    pix(8'h05);
    idle(3);

    bank_req_we = 1'b1;
    bank_req = 1'b0;
    frame_start = 1'b1;
    pix(8'h05);
    chk("direct0", 32'({active_bank, bank_pend}), 32'd0);
    bank_req = 1'b1;
    pix(8'h05);
    chk("direct1", 32'({active_bank, bank_pend}), 32'd2);
    bank_req_we = 1'b0;
    frame_start = 1'b0;
    pix(8'h05);
    idle(3);

    pix(8'h00);
    pix(8'h21);
    pix(8'h05);
    #2 Reset = 1'b1;
    pix_valid = 1'b0;
    #1;
    chk("mid_rst_out",
        32'({out_valid, out_transp, red, green, blue}), 32'd0);
    chk("mid_rst_bank", 32'({active_bank, bank_pend}), 32'd0);
    q.delete();
    m_bank = '0;
    m_pend = 1'b0;
    m_pendv = '0;
    @(posedge Clk); edge_cnt++;
    #2 Reset = 1'b0;
    idle(4);
    pix(8'h05);
    idle(3);

    chk("drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
